psum_acc_ctrl: RTL

PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

---
 rtl/psum_acc_if.sv | 35 +++
 rtl/psum_acc_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_if.sv
// Handshake and data bundle for psum_acc_ctrl.
//   slave  : accumulator side (consumes start/config/OFIFO rows, produces writes/status)
//   master : driver side (testbench or surrounding array controller)
// Signals: start, num_tiles, num_rows, ofifo_valid, ofifo_rd, ofifo_out,
//          out_valid, out_addr, out_data, busy, done.
interface psum_acc_if #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 16
);
    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned DW = psum_bw * col;

    logic          start;
    logic [3:0]    num_tiles;
    logic [AW:0]   num_rows;
    logic          ofifo_valid;
    logic          ofifo_rd;
    logic [DW-1:0] ofifo_out;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    modport slave (
        input  start, num_tiles, num_rows, ofifo_valid, ofifo_out,
        output ofifo_rd, out_valid, out_addr, out_data, busy, done
    );

    modport master (
        output start, num_tiles, num_rows, ofifo_valid, ofifo_out,
        input  ofifo_rd, out_valid, out_addr, out_data, busy, done
    );
endinterface

// File: rtl/psum_acc_ctrl.sv
// Partial-sum accumulation controller.
// Drains num_tiles x num_rows rows from the OFIFO into a local row buffer
// (tile 0 overwrites, later tiles add per column with wrap-around), then
// flushes num_rows accumulated rows to psum memory, one per cycle.
// Ports:
//   clk, reset (async, active-high)
//   bus (psum_acc_if.slave): start/num_tiles/num_rows job request,
//       ofifo_valid/ofifo_rd/ofifo_out row input (ofifo_rd is combinational),
//       out_valid/out_addr/out_data memory write, busy/done status (registered).
// Build option: define PSUM_RELU_EN to clamp negative columns to 0 on flush.
module psum_acc_ctrl #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 16
) (
    input  logic        clk,
    input  logic        reset,
    psum_acc_if.slave   bus
);
    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned RW = AW + 1;
    localparam int unsigned DW = psum_bw * col;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    tiles_q, tiles_d;
    logic [RW-1:0] rows_q, rows_d;
    logic [AW-1:0] row_q, row_d;
    logic [3:0]    tile_q, tile_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          pop;
    logic [DW-1:0] acc_row;
    logic [3:0]    cfg_tiles;
    logic [RW-1:0] cfg_rows;
    logic          row_last, tile_last, addr_last;

    logic [DW-1:0] buffer [depth];

    // Optional ReLU on the flushed row
    function automatic logic [DW-1:0] xform(input logic [DW-1:0] r);
        logic [DW-1:0] o;
        o = r;
`ifdef PSUM_RELU_EN
        for (int c = 0; c < int'(col); c++) begin
            if (r[c*psum_bw + psum_bw - 1]) o[c*psum_bw +: psum_bw] = '0;
        end
`endif
        return o;
    endfunction

    // Sanitised job configuration (0 -> 1, rows clamp to depth)
    always_comb begin
        cfg_tiles = (bus.num_tiles == 4'd0) ? 4'd1 : bus.num_tiles;
        if (bus.num_rows == '0)
            cfg_rows = RW'(1);
        else if (bus.num_rows > RW'(depth))
            cfg_rows = RW'(depth);
        else
            cfg_rows = bus.num_rows;
    end

    // Row to be written: tile 0 overwrites, later tiles add column-wise
    always_comb begin
        acc_row = bus.ofifo_out;
        if (tile_q != 4'd0) begin
            for (int c = 0; c < int'(col); c++) begin
                acc_row[c*psum_bw +: psum_bw] = buffer[row_q][c*psum_bw +: psum_bw]
                                              + bus.ofifo_out[c*psum_bw +: psum_bw];
            end
        end
    end

    assign row_last  = (RW'(row_q) == rows_q - RW'(1));
    assign tile_last = (tile_q == tiles_q - 4'd1);
    assign addr_last = (RW'(out_addr_q) == rows_q - RW'(1));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        tiles_d     = tiles_q;
        rows_d      = rows_q;
        row_d       = row_q;
        tile_d      = tile_q;
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DRAIN;
                    tiles_d = cfg_tiles;
                    rows_d  = cfg_rows;
                    row_d   = '0;
                    tile_d  = '0;
                end
            end
            DRAIN: begin
                pop = bus.ofifo_valid;
                if (pop) begin
                    if (row_last) begin
                        row_d  = '0;
                        tile_d = tile_q + 4'd1;
                        if (tile_last) begin
                            // Preload flush row 0; bypass when it is the row being written now
                            state_d     = FLUSH;
                            out_valid_d = 1'b1;
                            out_addr_d  = '0;
                            out_data_d  = xform((row_q == '0) ? acc_row : buffer[0]);
                        end
                    end else begin
                        row_d = row_q + AW'(1);
                    end
                end
            end
            FLUSH: begin
                if (addr_last) begin
                    state_d = DONE;
                end else begin
                    out_valid_d = 1'b1;
                    out_addr_d  = out_addr_q + AW'(1);
                    out_data_d  = xform(buffer[out_addr_q + AW'(1)]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DRAIN) || (state_d == FLUSH);
        done_d = (state_d == DONE);
    end

    // State and control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tiles_q     <= '0;
            rows_q      <= '0;
            row_q       <= '0;
            tile_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tiles_q     <= tiles_d;
            rows_q      <= rows_d;
            row_q       <= row_d;
            tile_q      <= tile_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Accumulation buffer, intentionally not reset
    always_ff @(posedge clk) begin
        if (pop) buffer[row_q] <= acc_row;
    end

    assign bus.ofifo_rd  = pop;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
